coherence_bus_arbiter: RTL and testbench
========================================

// Module: coherence_bus_arbiter
// PURPOSE
//  Shared snoop-bus controller for the two-cpu SMP: arbitrates cache miss/invalidate requests, drives grant.
//  Snoops the non-granted cpu with the requester's block tag, then picks the data source (other cpu or unified memory).
//  Broadcasts invalidates to the non-granted cpu. Sits between both cpu cache_controller bus ports and unified memory.
// PARAMETERS
//  TAG_W     13   width of BICO/BOCI block tag
//  SNOOP_LAT 1    cycles from cpu_search assert to cpu_search_found valid (1..7)
//  MEM_TMO   255  max cycles waiting on u_rdy before err pulse (8-bit counter)
// PORTS
//  clk               in   1      clock
//  rst               in   1      synchronous active-high reset
//  read_miss         in   2      per-cpu read-miss request, bit i = cpu i
//  write_miss        in   2      per-cpu write-miss request
//  invalidate        in   2      per-cpu invalidate request (write hit on shared)
//  BICO              in   2*TAG_W per-cpu block tag; cpu i = [i*TAG_W +: TAG_W]
//  cpu_search_found  in   2      per-cpu snoop hit response
//  u_rdy             in   1      unified memory op complete
//  grant             out  2      one-hot grant, held for whole transaction
//  cpu_search        out  2      snoop strobe to non-granted cpu
//  BOCI              out  TAG_W  latched tag of granted requester
//  cpu_datasel       out  4      per-cpu 2b: 00 none, 01 unified mem, 10 other cpu, 11 rsvd
//  invalidate_from_other_cpu out 2  one-cycle invalidate pulse to non-granted cpu
//  busy              out  1      transaction in flight (state != IDLE)
//  err               out  1      one-cycle pulse on memory timeout
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, last_grant=1 (cpu0 wins first tie), counters 0. rst mid-transaction aborts to IDLE next edge.
//  req[i] = read_miss[i]|write_miss[i]|invalidate[i]. Priority per cpu: write_miss > read_miss > invalidate; kind latched at grant.
//  IDLE: none -> stay. One req -> grant it. Both -> grant ~last_grant; last_grant updated at grant. Registered: grant asserts
//    cycle after req seen. BOCI latched from winner's BICO same edge; stable until return to IDLE.
//  SNOOP: cpu_search[other]=1 for one cycle; wait SNOOP_LAT cycles; sample cpu_search_found[other] -> hit flag.
//  Transitions after SNOOP:
//   invalidate       -> INV.
//   read_miss & hit  -> XFER: cpu_datasel[winner]=10 one cycle -> DONE.
//   read_miss & !hit -> MEM.
//   write_miss       -> INV (iff hit) -> MEM; else MEM directly.
//  INV: invalidate_from_other_cpu[other]=1 exactly one cycle; then DONE (invalidate kind) or MEM (write_miss).
//  MEM: cpu_datasel[winner]=01 held; counter++ each cycle; u_rdy -> DONE. counter==MEM_TMO w/o u_rdy -> err pulse, DONE.
//    u_rdy outside MEM ignored.
//  DONE: grant held until winner's req drops (no stale re-grant); then grant=0, cpu_datasel=00, -> IDLE next cycle.
//    Requester holding req forever is legal; bus stays owned.
//  Non-granted cpu's requests wait in IDLE; never dropped; served next arbitration (round robin, no starvation).
//  grant never has both bits set; cpu_search/invalidate_from_other_cpu never target winner.
//  Min latency: req -> grant 1 cycle; read-miss snoop hit: grant -> datasel=10 at SNOOP_LAT+2 cycles.
// TESTING
//  cpu0 read_miss, cpu1 found=1 -> grant=01, cpu_search=10, BOCI=cpu0 tag, datasel0=10 one cycle, no u_rdy wait.
//  cpu1 read_miss 0x0A5, found=0, u_rdy after 4 cyc -> grant=10, datasel1=01 4 cyc, DONE, grant drops after req drops.
//  Both read_miss same cycle, repeated -> grants alternate 01,10,01; last_grant reset=1 so first=01.
//  cpu0 write_miss, cpu1 found=1 -> invalidate_from_other_cpu=10 one cycle, then datasel0=01 until u_rdy.
//  cpu1 read_miss, u_rdy never -> err pulses at MEM_TMO=255 cycles, return IDLE once req drops.
//  rst asserted in MEM -> next edge all outputs 0, busy=0; pending cpu0 req granted 1 cycle after rst release.

Source files
------------

// File: rtl/coherence_bus_arbiter_if.sv
// Snoop-bus bundle between the two cpu cache controllers, unified memory and
// the coherence bus arbiter.
//   master : arbiter side. It takes the per-cpu requests, block tags, snoop
//            responses and u_rdy. It drives grant, cpu_search, BOCI,
//            cpu_datasel, invalidate_from_other_cpu, busy and err.
//   slave  : cpu/memory side, with the opposite directions.
// Per-cpu vectors use bit i (or field i) for cpu i.
interface coherence_bus_arbiter_if #(
  parameter int TAG_W = 13
);
  logic [1:0]         read_miss;
  logic [1:0]         write_miss;
  logic [1:0]         invalidate;
  logic [2*TAG_W-1:0] BICO;
  logic [1:0]         cpu_search_found;
  logic               u_rdy;
  logic [1:0]         grant;
  logic [1:0]         cpu_search;
  logic [TAG_W-1:0]   BOCI;
  logic [3:0]         cpu_datasel;
  logic [1:0]         invalidate_from_other_cpu;
  logic               busy;
  logic               err;

  modport master (
    input  read_miss, write_miss, invalidate, BICO, cpu_search_found, u_rdy,
    output grant, cpu_search, BOCI, cpu_datasel, invalidate_from_other_cpu,
           busy, err
  );

  modport slave (
    output read_miss, write_miss, invalidate, BICO, cpu_search_found, u_rdy,
    input  grant, cpu_search, BOCI, cpu_datasel, invalidate_from_other_cpu,
           busy, err
  );
endinterface

// File: rtl/coherence_bus_arbiter.sv
// Shared snoop-bus controller for a two-cpu SMP.
// It arbitrates miss and invalidate requests with round-robin on ties. It
// snoops the non-granted cpu with the winner's tag, then picks the data
// source: the other cpu on a read-miss snoop hit, otherwise unified memory.
// It also broadcasts invalidates to the non-granted cpu.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset. It aborts any transaction.
//   bus  : coherence_bus_arbiter_if.master. Carries requests, tags, snoop
//          responses and u_rdy in. Carries grant, snoop strobe, latched tag,
//          data select, invalidate pulse, busy and err out.
module coherence_bus_arbiter #(
  parameter int TAG_W     = 13,
  parameter int SNOOP_LAT = 1,
  parameter int MEM_TMO   = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  coherence_bus_arbiter_if.master        bus
);

  localparam logic [2:0] SNOOP_LAT_C = 3'(SNOOP_LAT);
  localparam logic [7:0] MEM_TMO_C   = 8'(MEM_TMO);

  typedef enum logic [2:0] {
    S_IDLE, S_SNOOP, S_WAIT, S_EVAL, S_XFER, S_INV, S_MEM, S_DONE
  } state_t;

  typedef enum logic [1:0] {K_INV, K_RD, K_WR} kind_t;

  state_t           state, state_nx;
  kind_t            kind, kind_nx;
  logic             winner, winner_nx;
  logic             last_grant, last_grant_nx;
  logic             hit, hit_nx;
  logic [2:0]       snp_cnt, snp_cnt_nx;
  logic [7:0]       mem_cnt, mem_cnt_nx;
  logic [TAG_W-1:0] boci_q;
  logic [TAG_W-1:0] tag_sel;
  logic [1:0]       req;
  logic             other;
  logic             srch_en, inv_en, err_w;
  logic [1:0]       sel;

  // A cpu's request kind is fixed when it wins: write_miss > read_miss > invalidate.
  function automatic kind_t pick_kind(input logic wm, input logic rm);
    if (wm) return K_WR;
    if (rm) return K_RD;
    return K_INV;
  endfunction

  assign req     = bus.read_miss | bus.write_miss | bus.invalidate;
  assign other   = ~winner;
  assign tag_sel = winner_nx ? bus.BICO[2*TAG_W-1:TAG_W] : bus.BICO[TAG_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      kind       <= K_INV;
      winner     <= 1'b0;
      last_grant <= 1'b1;
      hit        <= 1'b0;
      snp_cnt    <= 3'd0;
      mem_cnt    <= 8'd0;
    end else begin
      state      <= state_nx;
      kind       <= kind_nx;
      winner     <= winner_nx;
      last_grant <= last_grant_nx;
      hit        <= hit_nx;
      snp_cnt    <= snp_cnt_nx;
      mem_cnt    <= mem_cnt_nx;
    end
  end

  // Tag tracks the prospective winner while idle and freezes once granted.
  // The output is gated by busy, so this register needs no reset.
  always_ff @(posedge clk) begin
    if (state == S_IDLE) boci_q <= tag_sel;
  end

  always_comb begin
    state_nx      = state;
    kind_nx       = kind;
    winner_nx     = winner;
    last_grant_nx = last_grant;
    hit_nx        = hit;
    snp_cnt_nx    = snp_cnt;
    mem_cnt_nx    = mem_cnt;
    srch_en       = 1'b0;
    inv_en        = 1'b0;
    err_w         = 1'b0;
    sel           = 2'b00;
    case (state)
      S_IDLE: begin
        if (|req) begin
          // Tie goes to the cpu that did not win last time.
          winner_nx     = (req == 2'b11) ? ~last_grant : req[1];
          last_grant_nx = winner_nx;
          kind_nx       = pick_kind(bus.write_miss[winner_nx], bus.read_miss[winner_nx]);
          state_nx      = S_SNOOP;
        end
      end
      S_SNOOP: begin
        srch_en    = 1'b1;
        snp_cnt_nx = 3'd1;
        state_nx   = S_WAIT;
      end
      S_WAIT: begin
        // The snoop response is valid SNOOP_LAT cycles after the strobe.
        if (snp_cnt == SNOOP_LAT_C) begin
          hit_nx   = bus.cpu_search_found[other];
          state_nx = S_EVAL;
        end else begin
          snp_cnt_nx = snp_cnt + 3'd1;
        end
      end
      S_EVAL: begin
        mem_cnt_nx = 8'd0;
        case (kind)
          K_INV:   state_nx = S_INV;
          K_RD:    state_nx = hit ? S_XFER : S_MEM;
          default: state_nx = hit ? S_INV : S_MEM;
        endcase
      end
      S_XFER: begin
        sel      = 2'b10;
        state_nx = S_DONE;
      end
      S_INV: begin
        inv_en     = 1'b1;
        mem_cnt_nx = 8'd0;
        state_nx   = (kind == K_WR) ? S_MEM : S_DONE;
      end
      S_MEM: begin
        sel = 2'b01;
        if (bus.u_rdy) begin
          state_nx = S_DONE;
        end else if (mem_cnt == MEM_TMO_C) begin
          err_w    = 1'b1;
          state_nx = S_DONE;
        end else begin
          mem_cnt_nx = mem_cnt + 8'd1;
        end
      end
      S_DONE: begin
        // Bus stays owned until the winner withdraws, so a held request is never re-granted.
        if (!req[winner]) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus.busy                      = (state != S_IDLE);
  assign bus.grant                     = bus.busy ? (winner ? 2'b10 : 2'b01) : 2'b00;
  assign bus.cpu_search                = srch_en ? (winner ? 2'b01 : 2'b10) : 2'b00;
  assign bus.invalidate_from_other_cpu = inv_en ? (winner ? 2'b01 : 2'b10) : 2'b00;
  assign bus.cpu_datasel               = winner ? {sel, 2'b00} : {2'b00, sel};
  assign bus.BOCI                      = bus.busy ? boci_q : '0;
  assign bus.err                       = err_w;

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Scoreboard bench for coherence_bus_arbiter.
// Each transaction pushes its expected outcome when its request is driven.
// A monitor then records what the bus did and pops the expectation to compare.
module tb_coherence_bus_arbiter;
  localparam int TAG_W     = 13;
  localparam int SNOOP_LAT = 1;
  localparam int MEM_TMO   = 255;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;

  coherence_bus_arbiter_if #(.TAG_W(TAG_W)) bus_if ();

  coherence_bus_arbiter #(
    .TAG_W(TAG_W), .SNOOP_LAT(SNOOP_LAT), .MEM_TMO(MEM_TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int               lat_g;
    logic [1:0]       gnt;
    logic [1:0]       gnt_end;
    logic [1:0]       srch;
    int               srch_len;
    logic [TAG_W-1:0] boci;
    logic [3:0]       dsel;
    int               dsel_t;
    int               dsel_len;
    logic [1:0]       inv;
    int               inv_t;
    int               inv_len;
    int               err_n;
    int               err_t;
    int               both_n;
  } txn_t;

  txn_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic [1:0] gnt, input logic [1:0] srch,
                              input logic [TAG_W-1:0] boci, input logic [3:0] dsel,
                              input int dsel_t, input int dsel_len, input logic [1:0] inv,
                              input int inv_t, input int inv_len, input int err_n,
                              input int err_t);
    txn_t r;
    r.lat_g    = 1;
    r.gnt      = gnt;
    r.gnt_end  = gnt;
    r.srch     = srch;
    r.srch_len = (srch != 2'b00) ? 1 : 0;
    r.boci     = boci;
    r.dsel     = dsel;
    r.dsel_t   = dsel_t;
    r.dsel_len = dsel_len;
    r.inv      = inv;
    r.inv_t    = inv_t;
    r.inv_len  = inv_len;
    r.err_n    = err_n;
    r.err_t    = err_t;
    r.both_n   = 0;
    return r;
  endfunction

  task automatic sb_compare(input string nm, input txn_t o);
    txn_t e;
    if (exp_q.size() == 0) begin
      chk({nm, ".sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk({nm, ".lat_grant"}, o.lat_g, e.lat_g);
    chk({nm, ".grant"}, o.gnt, e.gnt);
    chk({nm, ".grant_held"}, o.gnt_end, e.gnt_end);
    chk({nm, ".search"}, o.srch, e.srch);
    chk({nm, ".search_len"}, o.srch_len, e.srch_len);
    chk({nm, ".boci"}, o.boci, e.boci);
    chk({nm, ".datasel"}, o.dsel, e.dsel);
    chk({nm, ".datasel_t"}, o.dsel_t, e.dsel_t);
    chk({nm, ".datasel_len"}, o.dsel_len, e.dsel_len);
    chk({nm, ".inval"}, o.inv, e.inv);
    chk({nm, ".inval_t"}, o.inv_t, e.inv_t);
    chk({nm, ".inval_len"}, o.inv_len, e.inv_len);
    chk({nm, ".err_n"}, o.err_n, e.err_n);
    chk({nm, ".err_t"}, o.err_t, e.err_t);
    chk({nm, ".grant_both"}, o.both_n, e.both_n);
  endtask

  // Monitor plus cpu/memory responder for one transaction.
  // hit is the other cpu's snoop answer. mem_dly is the count of datasel=01
  // cycles before u_rdy, with 0 meaning memory never answers.
  task automatic observe(input string nm, input bit hit, input int mem_dly, input int window);
    txn_t o;
    int   g_t;
    int   srch_age;
    int   mem_cyc;
    o = mk(2'b00, 2'b00, '0, 4'b0000, 0, 0, 2'b00, 0, 0, 0, 0);
    o.lat_g   = 0;
    o.gnt_end = 2'b00;
    g_t       = 0;
    srch_age  = -1;
    mem_cyc   = 0;
    for (int t = 1; t <= window; t++) begin
      @(negedge clk);
      if (bus_if.grant == 2'b11) o.both_n++;
      if (g_t == 0 && bus_if.grant != 2'b00) begin
        g_t     = t;
        o.lat_g = t;
        o.gnt   = bus_if.grant;
        o.boci  = bus_if.BOCI;
      end
      o.gnt_end = bus_if.grant;
      if (bus_if.cpu_search != 2'b00) begin
        o.srch = o.srch | bus_if.cpu_search;
        o.srch_len++;
        srch_age = 0;
      end else if (srch_age >= 0) begin
        srch_age++;
      end
      if (bus_if.cpu_datasel != 4'b0000) begin
        if (o.dsel_len == 0) begin
          o.dsel   = bus_if.cpu_datasel;
          o.dsel_t = t - g_t;
        end
        o.dsel_len++;
      end
      if (bus_if.invalidate_from_other_cpu != 2'b00) begin
        if (o.inv_len == 0) begin
          o.inv   = bus_if.invalidate_from_other_cpu;
          o.inv_t = t - g_t;
        end
        o.inv_len++;
      end
      if (bus_if.err) begin
        o.err_n++;
        o.err_t = mem_cyc;
      end
      bus_if.u_rdy = 1'b0;
      if (bus_if.cpu_datasel == 4'b0001 || bus_if.cpu_datasel == 4'b0100) begin
        mem_cyc++;
        if (mem_dly > 0 && mem_cyc == mem_dly) bus_if.u_rdy = 1'b1;
      end
      bus_if.cpu_search_found = (hit && srch_age == SNOOP_LAT) ? ~o.gnt : 2'b00;
    end
    sb_compare(nm, o);
  endtask

  task automatic release_req(input string nm, input logic [1:0] m);
    bus_if.read_miss        = bus_if.read_miss & ~m;
    bus_if.write_miss       = bus_if.write_miss & ~m;
    bus_if.invalidate       = bus_if.invalidate & ~m;
    bus_if.u_rdy            = 1'b0;
    bus_if.cpu_search_found = 2'b00;
    @(negedge clk);
    chk({nm, ".rel_grant"}, bus_if.grant, 2'b00);
    chk({nm, ".rel_busy"}, bus_if.busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst    = 1'b1;
    bus_if.read_miss        = 2'b00;
    bus_if.write_miss       = 2'b00;
    bus_if.invalidate       = 2'b00;
    bus_if.BICO             = '0;
    bus_if.cpu_search_found = 2'b00;
    bus_if.u_rdy            = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.grant", bus_if.grant, 2'b00);
    chk("reset.busy", bus_if.busy, 1'b0);
    chk("reset.datasel", bus_if.cpu_datasel, 4'b0000);
    chk("reset.search", bus_if.cpu_search, 2'b00);
    chk("reset.boci", bus_if.BOCI, 13'h0);
    chk("reset.err", bus_if.err, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Simultaneous requests: first tie to cpu0, next tie to cpu1, then the pending cpu0 is served.
    bus_if.BICO      = {13'h0222, 13'h0111};
    bus_if.read_miss = 2'b11;
    exp_q.push_back(mk(2'b01, 2'b10, 13'h0111, 4'b0001, 3, 1, 2'b00, 0, 0, 0, 0));
    observe("rr1", 1'b0, 1, 10);
    release_req("rr1", 2'b11);
    bus_if.read_miss = 2'b11;
    exp_q.push_back(mk(2'b10, 2'b01, 13'h0222, 4'b0100, 3, 1, 2'b00, 0, 0, 0, 0));
    observe("rr2", 1'b0, 1, 10);
    release_req("rr2", 2'b10);
    exp_q.push_back(mk(2'b01, 2'b10, 13'h0111, 4'b0001, 3, 1, 2'b00, 0, 0, 0, 0));
    observe("rr3", 1'b0, 1, 10);
    release_req("rr3", 2'b01);

    // cpu0 read miss that hits in cpu1: cache-to-cache transfer.
    bus_if.BICO      = {13'h0000, 13'h1234};
    bus_if.read_miss = 2'b01;
    exp_q.push_back(mk(2'b01, 2'b10, 13'h1234, 4'b0010, 3, 1, 2'b00, 0, 0, 0, 0));
    observe("rd_hit", 1'b1, 0, 10);
    release_req("rd_hit", 2'b01);

    // cpu1 read miss from memory, u_rdy after 4 cycles.
    bus_if.BICO      = {13'h00A5, 13'h1FFF};
    bus_if.read_miss = 2'b10;
    exp_q.push_back(mk(2'b10, 2'b01, 13'h00A5, 4'b0100, 3, 4, 2'b00, 0, 0, 0, 0));
    observe("rd_mem", 1'b0, 4, 14);
    release_req("rd_mem", 2'b10);

    // cpu0 write miss (read bit also set, write wins) hitting in cpu1.
    bus_if.BICO       = {13'h0ABC, 13'h0F0F};
    bus_if.write_miss = 2'b01;
    bus_if.read_miss  = 2'b01;
    exp_q.push_back(mk(2'b01, 2'b10, 13'h0F0F, 4'b0001, 4, 3, 2'b10, 3, 1, 0, 0));
    observe("wr_hit", 1'b1, 3, 14);
    release_req("wr_hit", 2'b01);

    // cpu1 invalidate: pulse to cpu0, no data phase.
    bus_if.BICO       = {13'h1357, 13'h0000};
    bus_if.invalidate = 2'b10;
    exp_q.push_back(mk(2'b10, 2'b01, 13'h1357, 4'b0000, 0, 0, 2'b01, 3, 1, 0, 0));
    observe("inval", 1'b0, 0, 10);
    release_req("inval", 2'b10);

    // cpu0 write miss with no snoop hit goes straight to memory.
    bus_if.BICO       = {13'h0000, 13'h0246};
    bus_if.write_miss = 2'b01;
    exp_q.push_back(mk(2'b01, 2'b10, 13'h0246, 4'b0001, 3, 2, 2'b00, 0, 0, 0, 0));
    observe("wr_mem", 1'b0, 2, 12);
    release_req("wr_mem", 2'b01);

    // cpu1 read miss, memory never answers: err after MEM_TMO cycles in MEM.
    bus_if.BICO      = {13'h0DEF, 13'h0000};
    bus_if.read_miss = 2'b10;
    exp_q.push_back(mk(2'b10, 2'b01, 13'h0DEF, 4'b0100, 3, MEM_TMO + 1, 2'b00, 0, 0, 1, MEM_TMO));
    observe("tmo", 1'b0, 0, MEM_TMO + 20);
    release_req("tmo", 2'b10);

    // Reset during a memory wait, with cpu0 also requesting.
    bus_if.BICO      = {13'h00A5, 13'h0777};
    bus_if.read_miss = 2'b10;
    repeat (5) @(negedge clk);
    chk("rst_mid.in_mem", bus_if.cpu_datasel, 4'b0100);
    bus_if.read_miss = 2'b11;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid.grant", bus_if.grant, 2'b00);
    chk("rst_mid.busy", bus_if.busy, 1'b0);
    chk("rst_mid.datasel", bus_if.cpu_datasel, 4'b0000);
    chk("rst_mid.boci", bus_if.BOCI, 13'h0);
    chk("rst_mid.search", bus_if.cpu_search, 2'b00);
    chk("rst_mid.inval", bus_if.invalidate_from_other_cpu, 2'b00);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid.regrant", bus_if.grant, 2'b01);
    chk("rst_mid.regrant_boci", bus_if.BOCI, 13'h0777);
    chk("rst_mid.sb_left", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
